// File: rtl/if_id_hazard_ctrl_if.sv
// IF/ID hazard controller bus.
// Groups the fetch-side inputs, the ID/EX status inputs and the IF/ID register
// outputs with the stall/flush controls and event counters.
//   master : pipeline side; drives fetch and EX status, observes IF/ID and controls
//   slave  : hazard controller; consumes fetch and EX status, drives IF/ID and controls
interface if_id_hazard_ctrl_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        pc_stall;
    logic        idex_bubble;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output if_valid, if_instr, if_pc, ex_valid, ex_is_load, ex_rd, ex_redirect,
        input  id_instr, id_pc, id_valid, pc_stall, idex_bubble, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_valid, if_instr, if_pc, ex_valid, ex_is_load, ex_rd, ex_redirect,
        output id_instr, id_pc, id_valid, pc_stall, idex_bubble, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with load-use hazard detection and redirect flushing.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : if_id_hazard_ctrl_if.slave
//         in  if_valid/if_instr/if_pc, ex_valid/ex_is_load/ex_rd/ex_redirect
//         out id_valid/id_instr/id_pc (registered), pc_stall/idex_bubble
//             (combinational), stall_cnt/flush_cnt (saturating counters)
// Edge priority: rst, redirect (flush), load-use hazard (hold), normal advance.
module if_id_hazard_ctrl (
    input logic             clk,
    input logic             rst,
    if_id_hazard_ctrl_if.slave bus
);

    localparam logic [31:0] Nop       = 32'h0000_0013;
    localparam logic [6:0]  OpReg     = 7'b0110011;
    localparam logic [6:0]  OpImm     = 7'b0010011;
    localparam logic [6:0]  OpLoad    = 7'b0000011;
    localparam logic [6:0]  OpStore   = 7'b0100011;
    localparam logic [6:0]  OpBranch  = 7'b1100011;
    localparam logic [6:0]  OpJalr    = 7'b1100111;

    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;
    logic       redirect;

    assign opcode = id_instr_q[6:0];
    assign rs1    = id_instr_q[19:15];
    assign rs2    = id_instr_q[24:20];

    // Only formats that actually read a source register may raise a hazard, so
    // immediate fields of LUI/AUIPC/JAL that alias rs1/rs2 are ignored.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        unique case (opcode)
            OpReg, OpStore, OpBranch: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OpImm, OpLoad, OpJalr: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign hazard = id_valid_q & bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                    ((rs1_used & (rs1 == bus.ex_rd)) | (rs2_used & (rs2 == bus.ex_rd)));

    // Redirect is ignored while reset is held so no control leaks out.
    assign redirect = bus.ex_redirect & ~rst;

    assign bus.pc_stall    = hazard & ~redirect;
    assign bus.idex_bubble = hazard | redirect;

    always_comb begin
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            id_valid_d = 1'b0;
            id_instr_d = Nop;
            id_pc_d    = 32'd0;
            if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
        end else if (hazard) begin
            if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            id_valid_d = bus.if_valid;
            id_instr_d = bus.if_valid ? bus.if_instr : Nop;
            id_pc_d    = bus.if_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr_q  <= Nop;
            id_pc_q     <= 32'd0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench for if_id_hazard_ctrl: reset, advance, load-use stall,
// false-use filtering, redirect priority, bubble fetch, async reset, saturation.
module tb_if_id_hazard_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    if_id_hazard_ctrl_if bus ();

    if_id_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        bus.if_valid    = 1'b0;
        bus.if_instr    = 32'd0;
        bus.if_pc       = 32'd0;
        bus.ex_valid    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.ex_redirect = 1'b1;
        #1;
        // Reset values; redirect must be ignored while in reset
        check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_id_instr", bus.id_instr, 32'h0000_0013);
        check("rst_id_pc", bus.id_pc, 32'd0);
        check("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        check("rst_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
        check("rst_pc_stall", {31'd0, bus.pc_stall}, 32'd0);
        check("rst_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        step();
        step();
        #2;
        bus.ex_redirect = 1'b0;
        rst = 1'b0;

        // Normal advance: addi x2,x1,0
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h0000_8113;
        bus.if_pc    = 32'd100;
        step();
        check("adv_instr", bus.id_instr, 32'h0000_8113);
        check("adv_pc", bus.id_pc, 32'd100);
        check("adv_valid", {31'd0, bus.id_valid}, 32'd1);

        // Load-use on rs1
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd1;
        bus.if_instr   = 32'h0020_8193;
        bus.if_pc      = 32'd104;
        #1;
        check("lu_pc_stall", {31'd0, bus.pc_stall}, 32'd1);
        check("lu_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        step();
        check("lu_hold_instr", bus.id_instr, 32'h0000_8113);
        check("lu_hold_pc", bus.id_pc, 32'd100);
        check("lu_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);

        // Upstream clears ex_valid: stall ends, advance resumes
        bus.ex_valid = 1'b0;
        #1;
        check("lu_end_stall", {31'd0, bus.pc_stall}, 32'd0);
        check("lu_end_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        step();
        check("lu_resume_instr", bus.id_instr, 32'h0020_8193);
        check("lu_resume_pc", bus.id_pc, 32'd104);
        check("lu_resume_cnt", {16'd0, bus.stall_cnt}, 32'd1);

        // LUI x1: rs1 field aliases x1 but is not a register read
        bus.if_instr = 32'h0000_80B7;
        bus.if_pc    = 32'd108;
        step();
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd1;
        #1;
        check("lui_no_stall", {31'd0, bus.pc_stall}, 32'd0);
        check("lui_no_bubble", {31'd0, bus.idex_bubble}, 32'd0);

        // addi x2,x0,0 with load to x0: never a hazard
        bus.if_instr = 32'h0000_0113;
        bus.if_pc    = 32'd112;
        bus.ex_rd    = 5'd0;
        step();
        check("x0_instr", bus.id_instr, 32'h0000_0113);
        check("x0_no_stall", {31'd0, bus.pc_stall}, 32'd0);

        // add x3,x1,x2: hazard through rs2 only
        bus.if_instr = 32'h0020_81B3;
        bus.if_pc    = 32'd116;
        step();
        check("rtype_instr", bus.id_instr, 32'h0020_81B3);
        bus.ex_rd = 5'd2;
        #1;
        check("rs2_pc_stall", {31'd0, bus.pc_stall}, 32'd1);

        // Redirect together with hazard: flush wins, only flush_cnt counts
        bus.ex_redirect = 1'b1;
        #1;
        check("rd_pc_stall", {31'd0, bus.pc_stall}, 32'd0);
        check("rd_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        step();
        check("rd_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rd_instr", bus.id_instr, 32'h0000_0013);
        check("rd_pc", bus.id_pc, 32'd0);
        check("rd_flush_cnt", {16'd0, bus.flush_cnt}, 32'd1);
        check("rd_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);
        bus.ex_redirect = 1'b0;
        bus.ex_valid    = 1'b0;

        // Invalid fetch loads a NOP but keeps the PC
        bus.if_valid = 1'b0;
        bus.if_instr = 32'hDEAD_BEEF;
        bus.if_pc    = 32'd200;
        step();
        check("inv_valid", {31'd0, bus.id_valid}, 32'd0);
        check("inv_instr", bus.id_instr, 32'h0000_0013);
        check("inv_pc", bus.id_pc, 32'd200);

        // Async reset in the middle of a stall
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h0000_8113;
        bus.if_pc    = 32'd300;
        step();
        bus.ex_valid = 1'b1;
        bus.ex_rd    = 5'd1;
        step();
        check("ar_pre_stall_cnt", {16'd0, bus.stall_cnt}, 32'd2);
        bus.if_instr = 32'h0010_8093;
        bus.if_pc    = 32'd304;
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, bus.id_valid}, 32'd0);
        check("ar_instr", bus.id_instr, 32'h0000_0013);
        check("ar_pc", bus.id_pc, 32'd0);
        check("ar_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        check("ar_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
        check("ar_pc_stall", {31'd0, bus.pc_stall}, 32'd0);
        check("ar_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        #1;
        rst = 1'b0;
        step();
        check("ar_adv_instr", bus.id_instr, 32'h0010_8093);
        check("ar_adv_pc", bus.id_pc, 32'd304);
        check("ar_adv_valid", {31'd0, bus.id_valid}, 32'd1);

        // Saturation: addi x1,x1,1 against load to x1 stalls indefinitely
        #1;
        check("sat_hazard", {31'd0, bus.pc_stall}, 32'd1);
        repeat (65535) step();
        check("sat_full", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        step();
        check("sat_hold", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        check("sat_id_held", bus.id_instr, 32'h0010_8093);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
